// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational ROM and queues
// {pc, inst} pairs toward decode, with redirect, back-pressure, halt and range-fault handling.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          QDEPTH     = 2,
    parameter int          IMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    output logic        halted,
    output logic        fault
);
    localparam int              PW         = $clog2(QDEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [31:0]     PC_LIMIT   = 32'(IMEM_WORDS * 4);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(QDEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_STALL = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [31:0]   r_pc;
    logic [31:0]   r_q_inst [QDEPTH];
    logic [31:0]   r_q_pc   [QDEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_fault;

    logic          w_head_valid;
    logic          w_deq;
    logic          w_can_enq;
    logic          w_out_of_range;
    logic          w_fetching;
    logic          w_fault_set;
    logic          w_enq;
    logic          w_halt_op;
    logic [QDEPTH-1:0] w_wr_sel;

    assign w_head_valid   = (r_count != '0);
    assign w_deq          = w_head_valid && dec_ready;
    assign w_can_enq      = (r_count < FULL_COUNT) || w_deq;
    assign w_out_of_range = (r_pc >= PC_LIMIT);
    // Redirect wins over everything, so no fetch decision is made in that cycle.
    assign w_fetching     = !redirect_valid && (r_state != S_HALT);
    assign w_fault_set    = w_fetching && w_out_of_range;
    assign w_enq          = w_fetching && !w_out_of_range && w_can_enq;
    assign w_halt_op      = (imem_inst[6:0] == 7'h7F);

    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_wr_sel
        assign w_wr_sel[gi] = w_enq && (r_wptr == PW'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = S_FETCH;
        end else if (r_state != S_HALT) begin
            if (w_out_of_range) begin
                w_state_next = S_HALT;
            end else if (w_enq) begin
                w_state_next = w_halt_op ? S_HALT : S_FETCH;
            end else begin
                w_state_next = S_STALL;
            end
        end
    end

    always_comb begin
        imem_pc   = r_pc;
        dec_valid = w_head_valid;
        dec_inst  = r_q_inst[r_rptr];
        dec_pc    = r_q_pc[r_rptr];
        halted    = (r_state == S_HALT);
        fault     = r_fault;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc & ~32'h3;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_enq) begin
                r_pc   <= r_pc + 32'd4;
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CW'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - CW'(1);
            end
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (rst) begin
                r_q_inst[i] <= '0;
                r_q_pc[i]   <= '0;
            end else if (w_wr_sel[i]) begin
                r_q_inst[i] <= imem_inst;
                r_q_pc[i]   <= r_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, an end-of-ROM sequence, then random
// stimulus compared against a queue-based reference model of the fetch rules.
module tb_fetch_ctrl;
    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam int          QDEPTH     = 2;
    localparam int          IMEM_WORDS = 32;
    localparam int          AW         = $clog2(IMEM_WORDS);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_ready = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        halted;
    logic        fault;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] rom [IMEM_WORDS];

    always #5 clk = ~clk;

    assign imem_inst = (imem_pc < 32'(IMEM_WORDS * 4)) ? rom[imem_pc[AW+1:2]] : 32'hDEAD_BEE0;

    fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .QDEPTH     (QDEPTH),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready),
        .halted         (halted),
        .fault          (fault)
    );

    typedef struct {
        bit          rst;
        bit          rv;
        logic [31:0] rpc;
        bit          rdy;
        bit          e_dv;
        logic [31:0] e_dpc;
        logic [31:0] e_ipc;
        bit          e_h;
        bit          e_f;
    } vec_t;

    vec_t vt[$];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_fault;

    // Directed ROM image: word 5 carries the halt opcode, the rest never do.
    function automatic logic [31:0] romw(input int i);
        if (i == 5) return 32'h0000_007F;
        return 32'h13 | (32'(i) << 7);
    endfunction

    task automatic addv(input int r, input int rv, input int rpc, input int rdy,
                        input int dv, input int dpc, input int ipc, input int h, input int f);
        vec_t v;
        v.rst = (r != 0); v.rv = (rv != 0); v.rpc = 32'(rpc); v.rdy = (rdy != 0);
        v.e_dv = (dv != 0); v.e_dpc = 32'(dpc); v.e_ipc = 32'(ipc);
        v.e_h = (h != 0); v.e_f = (f != 0);
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit rv, input logic [31:0] rp, input bit rdy);
        @(negedge clk);
        rst = r;
        redirect_valid = rv;
        redirect_pc = rp;
        dec_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Reference model: one clock edge expressed as queue operations on {pc, inst} records.
    task automatic model_edge(input bit r, input bit rv, input logic [31:0] rp, input bit rdy);
        bit deq;
        if (r) begin
            m_pc = RESET_PC; m_q.delete(); m_halted = 0; m_fault = 0;
        end else if (rv) begin
            m_pc = rp & ~32'h3; m_q.delete(); m_halted = 0; m_fault = 0;
        end else begin
            deq = (m_q.size() > 0) && rdy;
            if (deq) void'(m_q.pop_front());
            if (!m_halted) begin
                if (m_pc >= 32'(IMEM_WORDS * 4)) begin
                    m_fault = 1; m_halted = 1;
                end else if (m_q.size() < QDEPTH) begin
                    m_q.push_back({m_pc, rom[m_pc[AW+1:2]]});
                    if (rom[m_pc[AW+1:2]][6:0] == 7'h7F) m_halted = 1;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        bit          r, rv, rdy;
        logic [31:0] rp;

        for (int i = 0; i < IMEM_WORDS; i++) rom[i] = romw(i);

        //   rst rv rpc   rdy | dv dpc   ipc   h f
        addv(1, 0, 0,    1,   0, 0,    0,    0, 0);
        addv(0, 0, 0,    1,   1, 0,    4,    0, 0);
        addv(0, 0, 0,    1,   1, 4,    8,    0, 0);
        addv(0, 0, 0,    1,   1, 8,    12,   0, 0);
        addv(0, 0, 0,    1,   1, 12,   16,   0, 0);
        addv(0, 0, 0,    1,   1, 16,   20,   0, 0);
        addv(0, 0, 0,    1,   1, 20,   24,   1, 0);
        addv(0, 0, 0,    1,   0, 0,    24,   1, 0);
        addv(0, 0, 0,    1,   0, 0,    24,   1, 0);
        addv(0, 1, 'h1B, 1,   0, 0,    'h18, 0, 0);
        addv(0, 0, 0,    1,   1, 'h18, 'h1C, 0, 0);
        addv(0, 0, 0,    0,   1, 'h18, 'h20, 0, 0);
        addv(0, 0, 0,    0,   1, 'h18, 'h20, 0, 0);
        addv(0, 0, 0,    0,   1, 'h18, 'h20, 0, 0);
        addv(0, 0, 0,    1,   1, 'h1C, 'h24, 0, 0);
        addv(0, 0, 0,    1,   1, 'h20, 'h28, 0, 0);
        addv(0, 1, 'h1B, 0,   0, 0,    'h18, 0, 0);
        addv(0, 0, 0,    1,   1, 'h18, 'h1C, 0, 0);
        addv(0, 1, 'h80, 1,   0, 0,    'h80, 0, 0);
        addv(0, 0, 0,    1,   0, 0,    'h80, 1, 1);
        addv(0, 0, 0,    1,   0, 0,    'h80, 1, 1);
        addv(0, 1, 'h4,  1,   0, 0,    'h04, 0, 0);
        addv(0, 0, 0,    0,   1, 'h04, 'h08, 0, 0);
        addv(0, 0, 0,    0,   1, 'h04, 'h0C, 0, 0);
        addv(0, 0, 0,    0,   1, 'h04, 'h0C, 0, 0);
        addv(1, 0, 0,    0,   0, 0,    0,    0, 0);
        addv(0, 0, 0,    1,   1, 0,    4,    0, 0);

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].rv, vt[i].rpc, vt[i].rdy);
            $display("vec %0d: dv=%0b dec_pc=%h dec_inst=%h imem_pc=%h halted=%0b fault=%0b",
                     i, dec_valid, dec_pc, dec_inst, imem_pc, halted, fault);
            check("dec_valid", 32'(dec_valid), 32'(vt[i].e_dv));
            check("imem_pc", imem_pc, vt[i].e_ipc);
            check("halted", 32'(halted), 32'(vt[i].e_h));
            check("fault", 32'(fault), 32'(vt[i].e_f));
            if (vt[i].e_dv) begin
                check("dec_pc", dec_pc, vt[i].e_dpc);
                check("dec_inst", dec_inst, romw(int'(vt[i].e_dpc >> 2)));
            end
            if (vt[i].rst) begin
                check("rst_dec_pc", dec_pc, 32'h0);
                check("rst_dec_inst", dec_inst, 32'h0);
            end
        end

        // Last ROM word fetched, then pc+4 leaves the ROM and faults.
        step(0, 1, 32'h7C, 1);
        $display("end-of-rom redirect: imem_pc=%h dv=%0b", imem_pc, dec_valid);
        check("eor_pc0", imem_pc, 32'h7C);
        check("eor_dv0", 32'(dec_valid), 32'h0);
        step(0, 0, 32'h0, 1);
        $display("end-of-rom fetch: dec_pc=%h imem_pc=%h fault=%0b", dec_pc, imem_pc, fault);
        check("eor_dv1", 32'(dec_valid), 32'h1);
        check("eor_dpc1", dec_pc, 32'h7C);
        check("eor_pc1", imem_pc, 32'h80);
        check("eor_fault1", 32'(fault), 32'h0);
        step(0, 0, 32'h0, 1);
        $display("end-of-rom fault: dv=%0b halted=%0b fault=%0b", dec_valid, halted, fault);
        check("eor_dv2", 32'(dec_valid), 32'h0);
        check("eor_halted2", 32'(halted), 32'h1);
        check("eor_fault2", 32'(fault), 32'h1);

        // Random phase on a random ROM image with sprinkled halt opcodes.
        step(1, 0, 32'h0, 1);
        for (int i = 0; i < IMEM_WORDS; i++) begin
            w = $urandom;
            if ($urandom_range(0, 9) == 0) w[6:0] = 7'h7F;
            else if (w[6:0] == 7'h7F) w[0] = 1'b0;
            rom[i] = w;
        end
        step(1, 0, 32'h0, 1);
        model_edge(1, 0, 32'h0, 1);

        for (int c = 0; c < 800; c++) begin
            r   = ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rp  = 32'($urandom_range(0, 39) * 4 + $urandom_range(0, 3));
            rdy = ($urandom_range(0, 9) < 7);
            step(r, rv, rp, rdy);
            model_edge(r, rv, rp, rdy);
            $display("rnd %0d: rst=%0b rv=%0b rpc=%h rdy=%0b -> dv=%0b dec_pc=%h imem_pc=%h h=%0b f=%0b",
                     c, r, rv, rp, rdy, dec_valid, dec_pc, imem_pc, halted, fault);
            check("rnd_dec_valid", 32'(dec_valid), 32'(m_q.size() > 0));
            check("rnd_imem_pc", imem_pc, m_pc);
            check("rnd_halted", 32'(halted), 32'(m_halted));
            check("rnd_fault", 32'(fault), 32'(m_fault));
            if (m_q.size() > 0) begin
                check("rnd_dec_pc", dec_pc, m_q[0].pc);
                check("rnd_dec_inst", dec_inst, m_q[0].inst);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
